// File: rtl/div_stall_unit.sv
// Multi-cycle radix-2 restoring divider for the EX stage.
// Holds the front of the pipeline through stallreq_o until {remainder, quotient} is ready.
module div_stall_unit #(
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic                  annul_i,
   input  logic                  signed_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   output logic [2*DATA_W-1:0]   result_o,
   output logic                  ready_o,
   output logic                  stallreq_o
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W);
   localparam logic [DATA_W-1:0] ONE_W    = DATA_W'(1);

   typedef enum logic [1:0] {
      ST_FREE   = 2'd0,
      ST_BYZERO = 2'd1,
      ST_ON     = 2'd2,
      ST_END    = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*DATA_W:0]   dividend_q, dividend_d;
   logic [DATA_W-1:0]   divisor_q, divisor_d;
   logic                s1_q, s1_d;
   logic                s2_q, s2_d;
   logic                signed_q, signed_d;
   logic [2*DATA_W-1:0] result_q, result_d;
   logic                ready_q, ready_d;

   logic [DATA_W-1:0]   op1_abs;
   logic [DATA_W-1:0]   op2_abs;
   logic [DATA_W:0]     diff;
   logic [DATA_W-1:0]   quo_raw;
   logic [DATA_W-1:0]   rem_raw;
   logic [DATA_W-1:0]   quo_fix;
   logic [DATA_W-1:0]   rem_fix;

   // Magnitudes are taken from the live inputs; they are only captured on acceptance.
   assign op1_abs = (signed_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + ONE_W) : opdata1_i;
   assign op2_abs = (signed_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + ONE_W) : opdata2_i;

   // Trial subtraction of the divisor from the partial remainder plus the next dividend bit.
   assign diff    = dividend_q[2*DATA_W:DATA_W] - {1'b0, divisor_q};
   assign quo_raw = dividend_q[DATA_W-1:0];
   assign rem_raw = dividend_q[2*DATA_W:DATA_W+1];
   assign quo_fix = (signed_q && (s1_q ^ s2_q)) ? (~quo_raw + ONE_W) : quo_raw;
   assign rem_fix = (signed_q && s1_q) ? (~rem_raw + ONE_W) : rem_raw;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      s1_d       = s1_q;
      s2_d       = s2_q;
      signed_d   = signed_q;
      result_d   = result_q;
      ready_d    = ready_q;
      stallreq_o = 1'b0;

      case (state_q)
         ST_FREE: begin
            result_d = '0;
            ready_d  = 1'b0;
            // Gated by rst so an EX request held through reset cannot raise a stall.
            if (start_i && !annul_i && rst) begin
               stallreq_o = 1'b1;
               cnt_d      = '0;
               dividend_d = {{DATA_W{1'b0}}, op1_abs, 1'b0};
               divisor_d  = op2_abs;
               s1_d       = opdata1_i[DATA_W-1];
               s2_d       = opdata2_i[DATA_W-1];
               signed_d   = signed_i;
               state_d    = (opdata2_i == '0) ? ST_BYZERO : ST_ON;
            end
         end

         ST_BYZERO: begin
            stallreq_o = 1'b1;
            result_d   = '0;
            if (annul_i) begin
               ready_d = 1'b0;
               state_d = ST_FREE;
            end else begin
               ready_d = 1'b1;
               state_d = ST_END;
            end
         end

         ST_ON: begin
            stallreq_o = 1'b1;
            if (annul_i) begin
               result_d = '0;
               ready_d  = 1'b0;
               state_d  = ST_FREE;
            end else if (cnt_q != CNT_LAST) begin
               if (diff[DATA_W]) begin
                  dividend_d = {dividend_q[2*DATA_W-1:0], 1'b0};
               end else begin
                  dividend_d = {diff[DATA_W-1:0], dividend_q[DATA_W-1:0], 1'b1};
               end
               cnt_d = cnt_q + CNT_ONE;
            end else begin
               result_d = {rem_fix, quo_fix};
               ready_d  = 1'b1;
               state_d  = ST_END;
            end
         end

         ST_END: begin
            if (annul_i || !start_i) begin
               result_d = '0;
               ready_d  = 1'b0;
               state_d  = ST_FREE;
            end
         end

         default: begin
            result_d = '0;
            ready_d  = 1'b0;
            state_d  = ST_FREE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_FREE;
         cnt_q      <= '0;
         dividend_q <= '0;
         divisor_q  <= '0;
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         signed_q   <= 1'b0;
         result_q   <= '0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         signed_q   <= signed_d;
         result_q   <= result_d;
         ready_q    <= ready_d;
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_stall_unit.sv
// Directed bench for div_stall_unit: latency, stall window, signed/unsigned results,
// divide-by-zero, annul, async reset and operand isolation.
module tb_div_stall_unit;

   logic        clk;
   logic        rst;
   logic        start_i;
   logic        annul_i;
   logic        signed_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        stallreq_o;

   int checks   = 0;
   int failures = 0;

   div_stall_unit #(.DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start_i),
      .annul_i   (annul_i),
      .signed_i  (signed_i),
      .opdata1_i (opdata1_i),
      .opdata2_i (opdata2_i),
      .result_o  (result_o),
      .ready_o   (ready_o),
      .stallreq_o(stallreq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change 2 time units after the rising edge; outputs are sampled at the falling edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
      int cyc;
      int stall_cnt;
      logic got;
      step();
      start_i   = 1'b1;
      annul_i   = 1'b0;
      signed_i  = sgn;
      opdata1_i = a;
      opdata2_i = b;
      cyc       = 0;
      stall_cnt = 0;
      got       = 1'b0;
      while (!got && cyc < 60) begin
         @(negedge clk);
         if (ready_o) begin
            got = 1'b1;
         end else begin
            if (stallreq_o) stall_cnt++;
            step();
            cyc++;
            // Operands are scrambled after acceptance; the result must not depend on them.
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            signed_i  = 1'($urandom_range(0, 1));
         end
      end
      chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
      chk({tag, " stall_cycles"}, 64'(stall_cnt), 64'(exp_lat));
      chk({tag, " result"}, result_o, exp_res);
      chk({tag, " stall_in_end"}, 64'(stallreq_o), 64'd0);
      step();
      @(negedge clk);
      chk({tag, " ready_held"}, 64'(ready_o), 64'd1);
      chk({tag, " result_held"}, result_o, exp_res);
      step();
      start_i = 1'b0;
      step();
      @(negedge clk);
      chk({tag, " ready_cleared"}, 64'(ready_o), 64'd0);
      chk({tag, " result_cleared"}, result_o, 64'd0);
      chk({tag, " stall_free"}, 64'(stallreq_o), 64'd0);
      $display("txn %s sgn=%0b a=%h b=%h result=%h latency=%0d", tag, sgn, a, b, exp_res, cyc);
   endtask

   initial begin
      rst       = 1'b0;
      start_i   = 1'b0;
      annul_i   = 1'b0;
      signed_i  = 1'b0;
      opdata1_i = '0;
      opdata2_i = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset ready", 64'(ready_o), 64'd0);
      chk("reset result", result_o, 64'd0);
      chk("reset stall", 64'(stallreq_o), 64'd0);
      rst = 1'b1;
      step();

      // Main function
      run_div("udiv_100_7",   1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 34);
      run_div("sdiv_m7_2",    1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD, 34);
      run_div("sdiv_7_m2",    1'b1, 32'h00000007,   32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 34);
      run_div("sdiv_m7_m2",   1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   64'hFFFFFFFF_00000003, 34);
      run_div("udiv_fff9_2",  1'b0, 32'hFFFFFFF9,   32'h00000002,   64'h00000001_7FFFFFFC, 34);
      run_div("udiv_ffff_10", 1'b0, 32'hFFFFFFFF,   32'h00000010,   64'h0000000F_0FFFFFFF, 34);
      run_div("udiv_5_0",     1'b0, 32'd5,          32'd0,          64'd0,                 2);
      run_div("sdiv_m5_0",    1'b1, 32'hFFFFFFFB,   32'd0,          64'd0,                 2);
      run_div("sdiv_ovf",     1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 34);
      run_div("udiv_8000_ff", 1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 34);

      // Annul mid-divide at cycle 10, restart at cycle 12
      step();
      start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         chk("annul no_ready", 64'(ready_o), 64'd0);
         step();
      end
      annul_i = 1'b1;
      @(negedge clk);
      chk("annul c10 stall", 64'(stallreq_o), 64'd1);
      step();
      annul_i = 1'b0;
      start_i = 1'b0;
      @(negedge clk);
      chk("annul c11 stall", 64'(stallreq_o), 64'd0);
      chk("annul c11 ready", 64'(ready_o), 64'd0);
      chk("annul c11 result", result_o, 64'd0);
      $display("txn annul_at_cycle10 stall=%0b ready=%0b", stallreq_o, ready_o);
      run_div("udiv_1000_33", 1'b0, 32'd1000, 32'd33, 64'h0000000A_0000001E, 34);

      // Annul has priority over start in FREE
      step();
      start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd3;
      @(negedge clk);
      chk("free annul stall", 64'(stallreq_o), 64'd0);
      step();
      start_i = 1'b0; annul_i = 1'b0;
      @(negedge clk);
      chk("free annul stays_free", 64'(stallreq_o), 64'd0);
      $display("txn annul_in_free stall=%0b", stallreq_o);

      // Annul in END clears outputs even with start held
      step();
      start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd5; opdata2_i = 32'd0;
      step();
      step();
      @(negedge clk);
      chk("end annul ready_before", 64'(ready_o), 64'd1);
      annul_i = 1'b1;
      step();
      annul_i = 1'b0; start_i = 1'b0;
      @(negedge clk);
      chk("end annul ready_after", 64'(ready_o), 64'd0);
      $display("txn annul_in_end ready=%0b", ready_o);

      // Asynchronous reset at cycle 15 of a divide
      step();
      start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
      repeat (15) step();
      rst = 1'b0;
      #1;
      chk("async_rst stall", 64'(stallreq_o), 64'd0);
      chk("async_rst ready", 64'(ready_o), 64'd0);
      chk("async_rst result", result_o, 64'd0);
      $display("txn async_reset_cycle15 stall=%0b ready=%0b", stallreq_o, ready_o);
      start_i = 1'b0;
      step();
      rst = 1'b1;
      step();
      @(negedge clk);
      chk("after_rst free", 64'(stallreq_o), 64'd0);
      run_div("udiv_after_rst", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
